ex_mem_pipe: RTL

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe_if.sv | 61 ++++++
 rtl/ex_mem_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM stage bundle: EX-side beat in, MEM-side head beat out, flush and stall counter.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the EX side, out_valid/out_ready on the MEM side.
interface ex_mem_pipe_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SEL   = 5,
  parameter int CNT_W     = 16
);
  // EX side
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [WORD_SIZE-1:0] branch_target;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] rdata2;
  logic [REG_SEL-1:0]   rd;
  logic                 en_write_reg;
  logic                 alu_zero;
  logic                 alu_pos;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_write;
  logic                 write_source;

  // MEM side
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] branch_target_q;
  logic [WORD_SIZE-1:0] alu_result_q;
  logic [WORD_SIZE-1:0] rdata2_q;
  logic [REG_SEL-1:0]   rd_q;
  logic                 en_write_reg_q;
  logic                 alu_zero_q;
  logic                 alu_pos_q;
  logic                 branch_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic                 write_source_q;
  logic                 br_taken_q;
  logic [CNT_W-1:0]     stall_cnt;

  // Pipeline stage view
  modport slave (
    input  in_valid, flush, branch_target, alu_result, rdata2, rd,
           en_write_reg, alu_zero, alu_pos, branch, mem_read, mem_write,
           write_source, out_ready,
    output in_ready, out_valid, branch_target_q, alu_result_q, rdata2_q, rd_q,
           en_write_reg_q, alu_zero_q, alu_pos_q, branch_q, mem_read_q,
           mem_write_q, write_source_q, br_taken_q, stall_cnt
  );

  // Surrounding EX producer / MEM consumer view
  modport master (
    output in_valid, flush, branch_target, alu_result, rdata2, rd,
           en_write_reg, alu_zero, alu_pos, branch, mem_read, mem_write,
           write_source, out_ready,
    input  in_ready, out_valid, branch_target_q, alu_result_q, rdata2_q, rd_q,
           en_write_reg_q, alu_zero_q, alu_pos_q, branch_q, mem_read_q,
           mem_write_q, write_source_q, br_taken_q, stall_cnt
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush and saturating stall counter.
// Latency: one cycle from accept to head output when empty; EX_MEM_SKID_EN selects a 2-entry skid buffer.
// Backpressure: default in_ready = out_ready | ~out_valid (comb); skid build uses a registered in_ready, low when full.
module ex_mem_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  ex_mem_pipe_if.slave    bus
);

  typedef struct packed {
    logic [WORD_SIZE-1:0] branch_target;
    logic [WORD_SIZE-1:0] alu_result;
    logic [WORD_SIZE-1:0] rdata2;
    logic [REG_SEL-1:0]   rd;
    logic                 en_write_reg;
    logic                 alu_zero;
    logic                 alu_pos;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic                 write_source;
  } beat_t;

  beat_t            in_beat;
  beat_t            head_q;
  logic             out_valid_w;
  logic             in_ready_w;
  logic             accept;
  logic             drain;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Collect the EX-side fields into one beat word
  always_comb begin
    in_beat               = '0;
    in_beat.branch_target = bus.branch_target;
    in_beat.alu_result    = bus.alu_result;
    in_beat.rdata2        = bus.rdata2;
    in_beat.rd            = bus.rd;
    in_beat.en_write_reg  = bus.en_write_reg;
    in_beat.alu_zero      = bus.alu_zero;
    in_beat.alu_pos       = bus.alu_pos;
    in_beat.branch        = bus.branch;
    in_beat.mem_read      = bus.mem_read;
    in_beat.mem_write     = bus.mem_write;
    in_beat.write_source  = bus.write_source;
  end

  assign accept = bus.in_valid & in_ready_w;
  assign drain  = out_valid_w & bus.out_ready;

`ifdef EX_MEM_SKID_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  beat_t  tail_q;
  logic   in_ready_q;
  logic   load_head;
  logic   load_tail;
  logic   shift_up;

  // State register; in_ready is registered from the next state so it never depends on out_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  // Next-state: flush wins over any simultaneous accept or drain
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_ONE;
        S_ONE: begin
          if (accept && !drain)      state_d = S_TWO;
          else if (drain && !accept) state_d = S_EMPTY;
        end
        S_TWO:   if (drain) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Output decode: head valid, ready and the slot load/shift strobes
  always_comb begin
    out_valid_w = (state_q != S_EMPTY);
    in_ready_w  = in_ready_q;
    load_head   = accept & ~bus.flush &
                  ((state_q == S_EMPTY) | ((state_q == S_ONE) & drain));
    load_tail   = accept & ~bus.flush & (state_q == S_ONE) & ~drain;
    shift_up    = drain & ~bus.flush & (state_q == S_TWO);
  end

  // Payload slots move only on accept or when the head drains out of a full buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)     head_q <= in_beat;
      else if (shift_up) head_q <= tail_q;
      if (load_tail)     tail_q <= in_beat;
    end
  end
`else
  logic full_q;
  logic alive_q;

  // Holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive_q <= 1'b0;
    else      alive_q <= 1'b1;
  end

  // Single holding register; flush empties it and discards the incoming beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      head_q <= '0;
    end else begin
      if (bus.flush)  full_q <= 1'b0;
      else if (accept) full_q <= 1'b1;
      else if (drain)  full_q <= 1'b0;
      if (accept && !bus.flush) head_q <= in_beat;
    end
  end

  assign out_valid_w = full_q;
  assign in_ready_w  = alive_q & (bus.out_ready | ~full_q);
`endif

  // Stall counter saturates at all-ones and is untouched by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_w && !bus.out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.in_ready        = in_ready_w;
  assign bus.out_valid       = out_valid_w;
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.branch_target_q = head_q.branch_target;
  assign bus.alu_result_q    = head_q.alu_result;
  assign bus.rdata2_q        = head_q.rdata2;
  assign bus.rd_q            = head_q.rd;
  assign bus.alu_zero_q      = head_q.alu_zero;
  assign bus.alu_pos_q       = head_q.alu_pos;
  assign bus.branch_q        = head_q.branch;
  assign bus.write_source_q  = head_q.write_source;
  // Side-effecting controls are forced low when no beat is presented
  assign bus.en_write_reg_q  = head_q.en_write_reg & out_valid_w;
  assign bus.mem_read_q      = head_q.mem_read & out_valid_w;
  assign bus.mem_write_q     = head_q.mem_write & out_valid_w;
  assign bus.br_taken_q      = head_q.branch & head_q.alu_zero & out_valid_w;

endmodule
